// File: rtl/pc_fetch_unit.sv
// Program-counter and instruction-fetch front end: issues one registered
// request at a time, fills a single decode slot, and handles branch redirects.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_INC   = 32'd4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] add_a,
    output logic [31:0] add_b,
    input  logic [31:0] add_sum,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    input  logic        id_ready
);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        req_q, req_d;
    logic [31:0] addr_q, addr_d;
    logic        vld_q, vld_d;
    logic [31:0] ifpc_q, ifpc_d;
    logic [31:0] instr_q, instr_d;
    logic        slot_free;

    assign add_a     = pc_q;
    assign add_b     = PC_INC;
    assign imem_req  = req_q;
    assign imem_addr = addr_q;
    assign if_valid  = vld_q;
    assign if_pc     = ifpc_q;
    assign if_instr  = instr_q;

    // The slot counts as free if it is empty or being consumed this cycle.
    assign slot_free = !vld_q || id_ready;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        req_d   = req_q;
        addr_d  = addr_q;
        vld_d   = vld_q;
        ifpc_d  = ifpc_q;
        instr_d = instr_q;

        if (vld_q && id_ready) vld_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (!branch_taken && !stall && slot_free) begin
                    state_d = FETCH;
                    req_d   = 1'b1;
                    addr_d  = pc_q;
                end
            end
            FETCH: begin
                if (imem_ack) begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                    if (!branch_taken) begin
                        vld_d   = 1'b1;
                        ifpc_d  = addr_q;
                        instr_d = imem_rdata;
                        pc_d    = add_sum;
                    end
                end else if (branch_taken) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (imem_ack) begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        // Redirect overrides every other pc/slot update, including a same-cycle load.
        if (branch_taken) begin
            pc_d  = branch_target;
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            req_q   <= 1'b0;
            addr_q  <= 32'h0;
            vld_q   <= 1'b0;
            ifpc_q  <= 32'h0;
            instr_q <= 32'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            vld_q   <= vld_d;
            ifpc_q  <= ifpc_d;
            instr_q <= instr_d;
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: transaction-level fetch model compared every
// cycle, a latency-programmable memory responder, and literal spot checks.
module tb_pc_fetch_unit;

    localparam logic [31:0] INC = 32'd4;
    localparam logic [31:0] K   = 32'hA5A5_A5A5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] add_a, add_b, add_sum;
    logic        branch_taken, stall, id_ready;
    logic [31:0] branch_target;
    logic        imem_req, imem_ack, if_valid;
    logic [31:0] imem_addr, imem_rdata, if_pc, if_instr;

    // Second instance exercises a reset PC at the top of the address space.
    logic [31:0] add_a2, add_b2, add_sum2, addr2, rdata2, if_pc2, if_instr2;
    logic        req2, ack2, if_valid2;

    always #5 clk = ~clk;

    assign add_sum  = add_a + add_b;
    assign add_sum2 = add_a2 + add_b2;
    assign ack2     = req2;
    assign rdata2   = addr2 ^ K;

    pc_fetch_unit dut (
        .clk(clk), .rst_n(rst_n), .add_a(add_a), .add_b(add_b), .add_sum(add_sum),
        .branch_taken(branch_taken), .branch_target(branch_target), .stall(stall),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .if_valid(if_valid), .if_pc(if_pc),
        .if_instr(if_instr), .id_ready(id_ready)
    );

    pc_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
        .clk(clk), .rst_n(rst_n), .add_a(add_a2), .add_b(add_b2), .add_sum(add_sum2),
        .branch_taken(1'b0), .branch_target(32'h0), .stall(1'b0),
        .imem_req(req2), .imem_addr(addr2), .imem_ack(ack2),
        .imem_rdata(rdata2), .if_valid(if_valid2), .if_pc(if_pc2),
        .if_instr(if_instr2), .id_ready(1'b1)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Model: pc, one outstanding request (possibly killed), one decode slot.
    logic [31:0] m_pc, m_addr, m_ifpc, m_instr;
    logic        m_out, m_kill, m_vld;

    // Memory responder state.
    int   lat = 1;
    int   mem_wait = 0;
    logic ack_done = 1'b0;
    logic force_ack = 1'b0;

    logic [31:0] loads[$];
    int          load_cyc[$];
    logic [31:0] issued[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_addr = 32'h0; m_ifpc = 32'h0; m_instr = 32'h0;
        m_out = 1'b0; m_kill = 1'b0; m_vld = 1'b0;
        mem_wait = 0; ack_done = 1'b0;
    endtask

    task automatic compare_all();
        chk("add_a", add_a, m_pc);
        chk("add_b", add_b, INC);
        chk("imem_req", {31'b0, imem_req}, {31'b0, m_out});
        chk("imem_addr", imem_addr, m_addr);
        chk("if_valid", {31'b0, if_valid}, {31'b0, m_vld});
        if (m_vld) begin
            chk("if_pc", if_pc, m_ifpc);
            chk("if_instr", if_instr, m_instr);
        end
    endtask

    // One clock: drive inputs, advance the model, check after the edge.
    task automatic step(input logic br, input logic [31:0] tgt, input logic st, input logic rdy);
        logic        ack, ld;
        logic [31:0] rd;
        logic [31:0] n_pc, n_addr, n_ifpc, n_instr;
        logic        n_out, n_kill, n_vld, prev_out;
        ack = 1'b0;
        if (imem_req && !ack_done) begin
            mem_wait++;
            if (mem_wait >= lat) begin
                ack = 1'b1;
                ack_done = 1'b1;
            end
        end else if (!imem_req) begin
            mem_wait = 0;
            ack_done = 1'b0;
        end
        if (force_ack) ack = 1'b1;
        rd = imem_addr ^ K;
        branch_taken = br; branch_target = tgt; stall = st; id_ready = rdy;
        imem_ack = ack; imem_rdata = rd;

        n_pc = m_pc; n_addr = m_addr; n_ifpc = m_ifpc; n_instr = m_instr;
        n_out = m_out; n_kill = m_kill; n_vld = m_vld; ld = 1'b0;
        if (m_vld && rdy) n_vld = 1'b0;
        if (m_out && ack) begin
            if (!m_kill && !br) begin
                ld = 1'b1; n_vld = 1'b1; n_ifpc = m_addr; n_instr = rd; n_pc = m_pc + INC;
            end
            n_out = 1'b0; n_kill = 1'b0;
        end else begin
            if (m_out && br) n_kill = 1'b1;
            if (!m_out && !br && !st && (!m_vld || rdy)) begin
                n_out = 1'b1; n_addr = m_pc;
            end
        end
        if (br) begin
            n_pc = tgt; n_vld = 1'b0;
        end

        @(posedge clk);
        #1;
        cyc++;
        prev_out = m_out;
        m_pc = n_pc; m_addr = n_addr; m_ifpc = n_ifpc; m_instr = n_instr;
        m_out = n_out; m_kill = n_kill; m_vld = n_vld;
        compare_all();
        if (ld) begin
            loads.push_back(if_pc);
            load_cyc.push_back(cyc);
        end
        if (m_out && !prev_out) issued.push_back(imem_addr);
        @(negedge clk);
        branch_taken = 1'b0;
        imem_ack = 1'b0;
    endtask

    initial begin
        int nl;
        branch_taken = 1'b0; branch_target = 32'h0; stall = 1'b0; id_ready = 1'b1;
        imem_ack = 1'b0; imem_rdata = 32'h0;
        model_reset();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("rst imem_req", {31'b0, imem_req}, 32'h0);
        chk("rst imem_addr", imem_addr, 32'h0);
        chk("rst if_valid", {31'b0, if_valid}, 32'h0);
        chk("rst if_pc", if_pc, 32'h0);
        chk("rst if_instr", if_instr, 32'h0);
        chk("rst add_a", add_a, 32'h0);
        chk("rst2 add_a", add_a2, 32'hFFFF_FFFC);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Straight-line fetch, 1-cycle memory; dut2 checked for wrap-around.
        lat = 1;
        step(1'b0, 32'h0, 1'b0, 1'b1);
        chk("first imem_addr", imem_addr, 32'h0);
        chk("first imem_req", {31'b0, imem_req}, 32'h1);
        chk("dut2 first addr", addr2, 32'hFFFF_FFFC);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        chk("dut2 if_pc", if_pc2, 32'hFFFF_FFFC);
        chk("dut2 if_instr", if_instr2, 32'h5A5A_5A59);
        chk("dut2 pc wrap", add_a2, 32'h0);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        chk("dut2 second addr", addr2, 32'h0);
        repeat (5) step(1'b0, 32'h0, 1'b0, 1'b1);
        chk("seq load count", loads.size(), 4);
        if (loads.size() >= 4) begin
            chk("seq pc0", loads[0], 32'h0);
            chk("seq pc1", loads[1], 32'h4);
            chk("seq pc2", loads[2], 32'h8);
            chk("seq pc3", loads[3], 32'hC);
            for (int i = 0; i < 3; i++) chk("seq interval", load_cyc[i+1] - load_cyc[i], 2);
        end
        chk("seq last instr", if_instr, 32'hA5A5_A5A9);

        // Branch while a 3-cycle fetch is in flight: stale word must vanish.
        lat = 3;
        nl = loads.size();
        step(1'b0, 32'h0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        step(1'b1, 32'h100, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        chk("drain no load", loads.size(), nl);
        chk("redirect addr", issued[$], 32'h100);
        repeat (3) step(1'b0, 32'h0, 1'b0, 1'b1);
        chk("redirect load", loads[$], 32'h100);
        chk("redirect instr", if_instr, 32'hA5A5_A4A5);

        // Back-pressure from decode.
        lat = 1;
        repeat (4) step(1'b0, 32'h0, 1'b0, 1'b0);
        chk("bp no req", {31'b0, imem_req}, 32'h0);
        chk("bp if_pc hold", if_pc, 32'h100);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        chk("bp accept req", {31'b0, imem_req}, 32'h1);
        chk("bp accept addr", imem_addr, 32'h104);
        repeat (4) step(1'b0, 32'h0, 1'b0, 1'b0);

        // Stall with a request outstanding.
        lat = 3;
        step(1'b0, 32'h0, 1'b0, 1'b1);
        repeat (6) step(1'b0, 32'h0, 1'b1, 1'b1);
        chk("stall load", loads[$], 32'h108);
        chk("stall pc", add_a, 32'h10C);
        chk("stall no req", {31'b0, imem_req}, 32'h0);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        chk("unstall addr", imem_addr, 32'h10C);

        // Asynchronous reset mid-request, then a late ack in IDLE.
        step(1'b0, 32'h0, 1'b0, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst imem_req", {31'b0, imem_req}, 32'h0);
        chk("arst imem_addr", imem_addr, 32'h0);
        chk("arst if_valid", {31'b0, if_valid}, 32'h0);
        chk("arst add_a", add_a, 32'h0);
        #1 rst_n = 1'b1;
        force_ack = 1'b1;
        step(1'b0, 32'h0, 1'b1, 1'b1);
        force_ack = 1'b0;
        chk("late ack ignored", {31'b0, if_valid}, 32'h0);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        chk("restart addr", imem_addr, 32'h0);
        chk("restart req", {31'b0, imem_req}, 32'h1);
        repeat (3) step(1'b0, 32'h0, 1'b0, 1'b1);
        chk("restart load", loads[$], 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 SHALL have parameter PC_INC, default 32'd4, increment constant driven to the external 32-bit adder.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port clk  in  1  rising-edge clock.
REQ-005 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have port add_a  out  32  current PC to the adder's d1 input.
REQ-007 SHALL have port add_b  out  32  constant PC_INC to the adder's d2 input.
REQ-008 SHALL have port add_sum  in  32  adder out, i.e. PC+PC_INC, combinational, same cycle.
REQ-009 SHALL have port branch_taken  in  1  redirect strobe, one-cycle pulse.
REQ-010 SHALL have port branch_target  in  32  redirect PC, sampled when branch_taken=1.
REQ-011 SHALL have port stall  in  1  inhibits issue of new fetch requests.
REQ-012 SHALL have port imem_req  out  1  registered instruction-memory request.
REQ-013 SHALL have port imem_addr  out  32  registered request address.
REQ-014 SHALL have port imem_ack  in  1  memory completion, one-cycle pulse.
REQ-015 SHALL have port imem_rdata  in  32  instruction word, valid with imem_ack.
REQ-016 SHALL have ports if_valid/if_pc/if_instr  out  1/32/32  fetched-instruction slot to decode.
REQ-017 SHALL have port id_ready  in  1  decode accepts slot when if_valid&id_ready.

Function
REQ-018 SHALL drive add_a=pc and add_b=PC_INC continuously; pc changes only per REQ-022/REQ-025.
REQ-019 SHALL implement FSM states IDLE (no request outstanding), FETCH (live request), DRAIN (killed request awaiting ack).
REQ-020 IDLE->FETCH SHALL occur when !stall, !branch_taken and slot free-or-draining (if_valid=0 or id_ready=1); same edge sets imem_req=1, imem_addr=pc.
REQ-021 imem_req and imem_addr SHALL stay stable in FETCH/DRAIN until the ack cycle; imem_req SHALL drop on the edge after ack.
REQ-022 FETCH with imem_ack and no branch: load slot (if_valid=1, if_pc=imem_addr, if_instr=imem_rdata), pc<=add_sum, ->IDLE.
REQ-023 Minimum issue interval SHALL be 2 cycles (ack-in-1-cycle memory: one instruction per 2 cycles).
REQ-024 Slot SHALL clear (if_valid=0) on if_valid&id_ready unless reloaded that edge; if_pc/if_instr hold while if_valid=1 and not accepted.
REQ-025 branch_taken in any state SHALL set pc<=branch_target and clear if_valid, with priority over stall, ack and slot load.
REQ-026 branch_taken in FETCH without ack: ->DRAIN; with ack same cycle: data discarded, ->IDLE.
REQ-027 DRAIN on imem_ack SHALL discard imem_rdata, not change pc, ->IDLE; branch in DRAIN updates pc (latest target wins).
REQ-028 stall SHALL NOT abort an outstanding request; ack under stall is captured normally.
REQ-029 imem_ack in IDLE SHALL be ignored.
REQ-030 pc wrap-around SHALL follow adder modulo 2^32 (32'hFFFF_FFFC+4 -> 0).

Reset
REQ-031 rst_n=0 SHALL immediately force pc=RESET_PC, state=IDLE, imem_req=0, imem_addr=0, if_valid=0, if_pc=0, if_instr=0.
REQ-032 Reset mid-request SHALL abandon it; a late ack after reset release, arriving in IDLE, is ignored.
REQ-033 First request SHALL issue on the first rising edge after rst_n=1 with stall=0, imem_addr=RESET_PC.

Verification
REQ-034 Reset, stall=0, id_ready=1, 1-cycle ack, rdata=addr^32'hA5A5_A5A5 -> if_pc sequence 0,4,8,C, one valid every 2 cycles, if_instr matches.
REQ-035 3-cycle ack latency, branch_taken target 32'h100 during wait -> DRAIN, stale word never appears on if_valid, next imem_addr=32'h100.
REQ-036 id_ready=0 with slot full -> no new imem_req, if_pc/if_instr stable; id_ready=1 -> accept, next request issues same edge.
REQ-037 stall=1 asserted with request outstanding -> ack captured, pc advances by 4, no further request until stall=0.
REQ-038 RESET_PC=32'hFFFF_FFFC -> first if_pc=32'hFFFF_FFFC, second imem_addr=32'h0000_0000.
REQ-039 rst_n pulsed low while in FETCH -> outputs zero asynchronously, late ack ignored, restart at RESET_PC.
